wait_state_ram: RTL and testbench

// Parametrised single-port word RAM, successor to the testbench RAM model. Adds configurable wait states, a

---
 rtl/wait_state_ram.sv | 187 ++++++++++++++++++
 tb/tb_wait_state_ram.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_ram.sv
// -----------------------------------------------------------------------------
// wait_state_ram
//
// Single-port word RAM with a programmable number of wait states, a
// valid/ready request and response handshake, per-byte store enables and an
// error response for addresses beyond the end of the array. Only one request
// is in flight at a time.
//
// Optional feature macro: FB_DIRTY_EN
//   defined   : fbDirty flags any committed store (byte enables != 0) that
//               lands in [FB_START, FB_START+FB_BYTES); fbClear clears it,
//               and a set on the same edge takes priority over the clear.
//   undefined : fbDirty is tied low and fbClear is ignored.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   reqValid    in   request present
//   reqReady    out  RAM can accept a request (high only in IDLE)
//   reqStore    in   1 = store, 0 = load
//   reqAddr     in   byte address, low log2(DATA_WIDTH/8) bits ignored
//   reqData     in   store data
//   reqByteSel  in   store byte enables, bit i -> byte i
//   rspValid    out  response present
//   rspReady    in   consumer accepts the response
//   rspData     out  load data, 0 for stores and errors
//   rspError    out  address >= MEM_BYTES
//   fbDirty     out  frame buffer written since last clear
//   fbClear     in   clear fbDirty
//
// State | meaning
// IDLE  | reqReady high, waiting for reqValid; request fields latched on accept
// WAIT  | counting down wait states; memory access on the edge the count is 0
// RESP  | rspValid high with stable data/error until rspReady
// -----------------------------------------------------------------------------
module wait_state_ram #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_WIDTH  = 32,
  parameter int    MEM_BYTES   = 65536,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = "",
  parameter int    FB_START    = 'h8000,
  parameter int    FB_BYTES    = 'h1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqStore,
  input  logic [ADDR_WIDTH-1:0]   reqAddr,
  input  logic [DATA_WIDTH-1:0]   reqData,
  input  logic [DATA_WIDTH/8-1:0] reqByteSel,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [DATA_WIDTH-1:0]   rspData,
  output logic                    rspError,
  output logic                    fbDirty,
  input  logic                    fbClear
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BYTE_SH = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int WORDS   = MEM_BYTES / BYTES;
  localparam int WORD_AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Range checks are done in 64 bits so the full address is compared and
  // nothing above MEM_BYTES can alias onto low memory.
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              wait_count;
  logic                    store_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [BYTES-1:0]        sel_q;

  logic [DATA_WIDTH-1:0]   mem [WORDS];

  logic                    addr_err;
  logic [WORD_AW-1:0]      word_idx;
  logic                    access_now;
  logic                    commit;

  assign addr_err   = 64'(addr_q) >= MEM_LIMIT;
  assign word_idx   = addr_q[BYTE_SH +: WORD_AW];
  // The access edge is one past the end of the countdown, so a request
  // accepted at edge N responds after edge N+WAIT_STATES+1.
  assign access_now = (state == WAIT) && (wait_count == 4'd0);
  // Reset forces IDLE asynchronously, so an aborted store can never commit.
  assign commit     = access_now && store_q && !addr_err;

  // Memory array has no reset; only byte lanes with their enable set change.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (sel_q[i]) begin
          mem[word_idx][8*i +: 8] <= data_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      reqReady   <= 1'b1;
      rspValid   <= 1'b0;
      rspData    <= '0;
      rspError   <= 1'b0;
      wait_count <= '0;
      store_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            store_q    <= reqStore;
            addr_q     <= reqAddr;
            data_q     <= reqData;
            sel_q      <= reqByteSel;
            wait_count <= 4'(WAIT_STATES);
            reqReady   <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_count == 4'd0) begin
            rspValid <= 1'b1;
            rspError <= addr_err;
            rspData  <= (!store_q && !addr_err) ? mem[word_idx] : '0;
            state    <= RESP;
          end else begin
            wait_count <= wait_count - 4'd1;
          end
        end
        RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            rspData  <= '0;
            rspError <= 1'b0;
            reqReady <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          rspValid <= 1'b0;
          reqReady <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef FB_DIRTY_EN
  localparam logic [63:0] FB_LO = 64'(FB_START);
  localparam logic [63:0] FB_HI = 64'(FB_START) + 64'(FB_BYTES);

  logic fb_hit;

  assign fb_hit = commit && (|sel_q) &&
                  (64'(addr_q) >= FB_LO) && (64'(addr_q) < FB_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fbDirty <= 1'b0;
    end else if (fb_hit) begin
      fbDirty <= 1'b1;
    end else if (fbClear) begin
      fbDirty <= 1'b0;
    end
  end
`else
  logic unused_fb;

  assign unused_fb = fbClear ^ (FB_START == FB_BYTES);
  assign fbDirty   = 1'b0;
`endif

endmodule

// File: tb/tb_wait_state_ram.sv
module tb_wait_state_ram;

  localparam int WS = 3;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        reqValid   = 1'b0;
  logic        reqReady;
  logic        reqStore   = 1'b0;
  logic [31:0] reqAddr    = '0;
  logic [31:0] reqData    = '0;
  logic [3:0]  reqByteSel = '0;
  logic        rspValid;
  logic        rspReady   = 1'b0;
  logic [31:0] rspData;
  logic        rspError;
  logic        fbDirty;
  logic        fbClear    = 1'b0;

  always #5 clk = ~clk;

  wait_state_ram #(.WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqStore(reqStore),
    .reqAddr(reqAddr), .reqData(reqData), .reqByteSel(reqByteSel),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .rspError(rspError), .fbDirty(fbDirty), .fbClear(fbClear)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference memory: word index -> word value, only for words the bench wrote.
  logic [31:0] ref_mem [int];
  logic        dirty_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full request/response transaction, entered and left at a negedge.
  task automatic xact(input logic st, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sel, input int hold, input logic clr,
                      output logic [31:0] rd, output logic er);
    int c;
    c = 0;
    while (reqReady !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("idle_req_ready", 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqStore = st; reqAddr = a; reqData = d; reqByteSel = sel;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    reqStore = 1'($urandom); reqAddr = $urandom; reqData = $urandom; reqByteSel = 4'($urandom);
    c = 0;
    while (rspValid !== 1'b1 && c < 100) begin
      chk("busy_req_ready", 32'(reqReady), 32'd0);
      if (c == WS) fbClear = clr;
      @(negedge clk);
      fbClear = 1'b0;
      c++;
    end
    chk("latency", 32'(c), 32'(WS + 1));
    rd = rspData;
    er = rspError;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rspValid), 32'd1);
      chk("hold_rsp_data", rspData, rd);
      chk("hold_rsp_error", 32'(rspError), 32'(er));
      chk("hold_req_ready", 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    chk("done_rsp_valid", 32'(rspValid), 32'd0);
    chk("done_req_ready", 32'(reqReady), 32'd1);
  endtask

  task automatic op(input logic st, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] sel, input int hold, input logic clr,
                    input string tag, output logic [31:0] rd);
    logic        er;
    logic        er_exp;
    int          idx;
    logic [31:0] w;
    er_exp = (a >= 32'h10000);
    idx    = int'(a >> 2);
    xact(st, a, d, sel, hold, clr, rd, er);
    chk({tag, "_err"}, 32'(er), 32'(er_exp));
    if (st || er_exp) chk({tag, "_zero"}, rd, 32'h0);
    else if (ref_mem.exists(idx)) chk({tag, "_data"}, rd, ref_mem[idx]);
    if (st && !er_exp && (ref_mem.exists(idx) || sel == 4'hF)) begin
      w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (sel[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[idx] = w;
    end
`ifdef FB_DIRTY_EN
    if (st && !er_exp && sel != 4'h0 && a >= 32'h8000 && a < 32'h9000) dirty_exp = 1'b1;
    else if (clr) dirty_exp = 1'b0;
`endif
    chk({tag, "_fbdirty"}, 32'(fbDirty), 32'(dirty_exp));
  endtask

  task automatic clear_pulse();
    fbClear = 1'b1;
    @(negedge clk);
    fbClear = 1'b0;
    dirty_exp = 1'b0;
    chk("fb_clear", 32'(fbDirty), 32'(dirty_exp));
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          r;

    // Reset values
    #1 reset = 1'b0;
    #2;
    chk("rst_req_ready", 32'(reqReady), 32'd1);
    chk("rst_rsp_valid", 32'(rspValid), 32'd0);
    chk("rst_rsp_data", rspData, 32'h0);
    chk("rst_rsp_error", 32'(rspError), 32'd0);
    chk("rst_fb_dirty", 32'(fbDirty), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Preload words 0x00..0xFC and the top word
    for (int i = 0; i < 64; i++) op(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0, "init", rd);
    op(1'b1, 32'hFFFC, $urandom, 4'hF, 0, 1'b0, "init_top", rd);

    // Load latency with WS wait states (checked inside xact) and data
    op(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, "t2_load", rd);

    // Reset in the middle of a store's wait states aborts it
    op(1'b1, 32'h10, 32'h11111111, 4'hF, 0, 1'b0, "t1_pre", rd);
    reqValid = 1'b1; reqStore = 1'b1; reqAddr = 32'h10; reqData = 32'hDEADBEEF; reqByteSel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t1_rsp_valid", 32'(rspValid), 32'd0);
    chk("t1_req_ready", 32'(reqReady), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    dirty_exp = 1'b0;
    @(negedge clk);
    op(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "t1_load", rd);
    chk("t1_word", rd, 32'h11111111);

    // Byte-enable merge
    op(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, "t3_base", rd);
    op(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0, "t3_part", rd);
    op(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "t3_load", rd);
    chk("t3_merge", rd, 32'h11BB33DD);
    op(1'b1, 32'h24, 32'h12345678, 4'h0, 0, 1'b0, "nosel_store", rd);

    // Address range
    op(1'b1, 32'h10000, 32'hCAFEF00D, 4'hF, 0, 1'b0, "t4_err_store", rd);
    op(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, "t4_load0", rd);
    op(1'b0, 32'hFFFC, 32'h0, 4'h0, 0, 1'b0, "t4_top", rd);
    op(1'b0, 32'h10000, 32'h0, 4'h0, 0, 1'b0, "t4_err_load", rd);
    op(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 0, 1'b0, "t4_high", rd);

    // Response held while rspReady is low
    op(1'b0, 32'h20, 32'h0, 4'h0, 5, 1'b0, "t5_hold", rd);

    // Frame buffer dirty flag
    op(1'b1, 32'h8000, $urandom, 4'hF, 0, 1'b0, "t6_set", rd);
    clear_pulse();
    op(1'b1, 32'h9000, $urandom, 4'hF, 0, 1'b0, "t6_end", rd);
    op(1'b1, 32'h8FFC, $urandom, 4'h0, 0, 1'b0, "t6_nosel", rd);
    op(1'b1, 32'h18000, $urandom, 4'hF, 0, 1'b0, "t6_errst", rd);
    op(1'b1, 32'h8004, $urandom, 4'hF, 0, 1'b1, "t6_both", rd);
    op(1'b1, 32'h8FFC, $urandom, 4'hF, 0, 1'b0, "t6_last", rd);
    op(1'b0, 32'h8004, 32'h0, 4'h0, 0, 1'b1, "t6_clr_load", rd);

    // Randomized traffic against the reference model
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        a = $urandom;
        if (a < 32'h10000) a = a | 32'h10000;
      end else begin
        a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
      end
      op(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2),
         ($urandom_range(0, 7) == 0), "rnd", rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
